chunked_adder_seq: RTL
======================

// Module: chunked_adder_seq
// PURPOSE
//   Parametrised multi-cycle adder/subtractor. It adds CHUNK bits per clock, so a
//   WIDTH-bit operation takes WIDTH/CHUNK cycles. Carry is held in a register
//   between chunks.
//   Successor to the combinational ripple adder. Adds subtract mode, carry/borrow
//   chaining, signed overflow and zero flags, and a Start/Busy/Done handshake.
//   Serves the ALU datapath wherever area matters more than single-cycle latency.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   CHUNK  8   bits added per cycle. WIDTH % CHUNK != 0 is an elaboration error.
//              NCH = WIDTH/CHUNK.
// PORTS
//   Clk       in   1      clock, rising edge
//   ResetN    in   1      asynchronous active-low reset
//   Start     in   1      request; sampled only when Busy=0
//   Abort     in   1      synchronous cancel of a run in progress
//   Sub       in   1      0: A+B+CarryIn;  1: A-B-CarryIn (CarryIn acts as borrow)
//   CarryIn   in   1      carry-in (add) / borrow-in (sub)
//   DataA     in   WIDTH  operand A, sampled with Start
//   DataB     in   WIDTH  operand B, sampled with Start
//   RAdd      out  WIDTH  result; valid from Done until the next accepted Start
//   CarryOut  out  1      carry out of the MSB (sub: 1 = no borrow)
//   Overflow  out  1      signed overflow = carry into MSB ^ carry out of MSB
//   Zero      out  1      RAdd == 0
//   Busy      out  1      state == RUN
//   Done      out  1      single-cycle pulse: result and flags updated
// BEHAVIOUR
//   Reset (ResetN=0, async): state=IDLE, chunk idx=0, RAdd=0, CarryOut=0,
//     Overflow=0, Zero=1, Busy=0, Done=0, and all internal operand/carry regs=0.
//   States: IDLE, RUN, DONE.
//   Start acceptance:
//     - Accepted in IDLE or DONE when Start=1.
//     - On the accept edge, latch A and B' = Sub ? ~DataB : DataB.
//     - Latch carry = Sub ? ~CarryIn : CarryIn.
//     - Set idx=0 and move to RUN.
//   RUN, each edge:
//     - Compute slice[idx] = A[idx] + B'[idx] + carry, CHUNK bits wide.
//     - Store the sum chunk into the partial register. carry <= chunk carry-out.
//     - idx++.
//   Last chunk (idx = NCH-1):
//     - Load RAdd from the full partial result, and set CarryOut and Overflow.
//     - Set Zero = (result == 0) and move to DONE.
//   Flag rule: Overflow uses the carry into bit WIDTH-1, taken inside the last chunk.
//   Outputs: RAdd and the flags change only on the completion edge. Partial sums
//     are never visible.
//   DONE lasts one cycle with Done=1, then returns to IDLE. A Start accepted in
//     DONE goes straight to RUN (back-to-back, no idle cycle).
//   Latency: Start accepted at edge 0 -> chunk k processed at edge k+1 ->
//     Done high in the cycle after edge NCH. Throughput is one op per NCH+1 cycles.
//   Start while Busy=1: ignored, with no effect on the current operation.
//   Abort=1 in RUN: return to IDLE next edge. No Done pulse, and RAdd and the
//     flags keep their previous values. Abort has priority over completion on the
//     last chunk. Abort outside RUN is ignored, and Abort together with an
//     accepted Start in IDLE/DONE still accepts the Start.
//   Reset mid-run: immediate return to the reset state. No Done pulse.
//   Boundary cases:
//     - CHUNK == WIDTH: a single RUN cycle.
//     - CHUNK == 1: fully bit-serial, WIDTH RUN cycles.
//     - idx counter width = clog2(NCH), minimum 1.
//   All arithmetic is unsigned modulo 2^WIDTH. Signedness affects only Overflow.
// TESTING (WIDTH=32, CHUNK=8, NCH=4)
//   1. Add 0xFFFFFFFF+0x00000001, CarryIn=0 -> RAdd=0, CarryOut=1, Zero=1,
//      Overflow=0; Done 4 cycles after the accept edge.
//   2. Add 0x7FFFFFFF+1 -> 0x80000000, Overflow=1, CarryOut=0.
//      Add 0x0000_00FF+0x0000_0001 -> 0x100: carry crosses a chunk boundary.
//   3. Sub 5-7, CarryIn=0 -> 0xFFFFFFFE, CarryOut=0.
//      Sub 0x80000000-1 -> 0x7FFFFFFF, Overflow=1, CarryOut=1.
//      Sub 9-4, CarryIn=1 -> 4.
//   4. Start pulsed while Busy with other operands -> ignored; the original result
//      is returned. Abort at the 2nd RUN cycle -> IDLE, no Done, RAdd unchanged.
//   5. ResetN low mid-run -> all outputs at reset values immediately. Start held
//      high through DONE -> the second op completes NCH+1 cycles after the first Done.
//   6. Re-run cases 1-3 with CHUNK=32 and CHUNK=1 -> identical results, with Done
//      at 1 and 32 cycles respectively.

Source files
------------

// File: rtl/chunked_adder_seq.sv
// ---------------------------------------------------------------------------
// chunked_adder_seq
//   Multi-cycle adder/subtractor. Each clock it adds one CHUNK-bit slice of
//   the operands, so a WIDTH-bit operation takes WIDTH/CHUNK RUN cycles. The
//   carry between slices is held in a register. Subtraction is done as
//   A + ~B + ~borrow_in. Result and flags are updated only on the completion
//   edge, so partial sums are never visible on the outputs.
//
// Ports
//   Clk       in   1      clock, rising edge
//   ResetN    in   1      asynchronous active-low reset
//   Start     in   1      request, accepted in IDLE or DONE
//   Abort     in   1      synchronous cancel of a run in progress
//   Sub       in   1      0: A+B+CarryIn, 1: A-B-CarryIn (CarryIn = borrow)
//   CarryIn   in   1      carry-in / borrow-in
//   DataA     in   WIDTH  operand A, sampled with Start
//   DataB     in   WIDTH  operand B, sampled with Start
//   RAdd      out  WIDTH  result, valid from Done until the next accepted Start
//   CarryOut  out  1      carry out of the MSB (sub: 1 = no borrow)
//   Overflow  out  1      signed overflow
//   Zero      out  1      RAdd == 0
//   Busy      out  1      operation in progress
//   Done      out  1      single-cycle completion pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module chunked_adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Sub,
  input  logic             CarryIn,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic [WIDTH-1:0] RAdd,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  // Reject a chunk size that does not tile the operand width.
  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_chunk_check
    $error("chunked_adder_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q,   state_d;
  logic [IDXW-1:0]   idx_q,     idx_d;
  logic [WIDTH-1:0]  a_q,       a_d;
  logic [WIDTH-1:0]  b_q,       b_d;      // already inverted for subtract
  logic              carry_q,   carry_d;
  logic [WIDTH-1:0]  part_q,    part_d;
  logic [WIDTH-1:0]  radd_q,    radd_d;
  logic              cout_q,    cout_d;
  logic              ovf_q,     ovf_d;
  logic              zero_q,    zero_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic [CHUNK-1:0]  a_sl_s;
  logic [CHUNK-1:0]  b_sl_s;
  logic [CHUNK-1:0]  sum_s;
  logic              chunk_cout_s;
  logic              msb_cin_s;
  logic [WIDTH-1:0]  full_s;

  // Slice adder for the current chunk and the partial result including it.
  always_comb begin
    a_sl_s = a_q[int'(idx_q) * CHUNK +: CHUNK];
    b_sl_s = b_q[int'(idx_q) * CHUNK +: CHUNK];
    {chunk_cout_s, sum_s} = {1'b0, a_sl_s} + {1'b0, b_sl_s}
                          + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit of the slice; only meaningful on the last chunk,
    // where it is the carry into bit WIDTH-1.
    msb_cin_s = sum_s[CHUNK-1] ^ a_sl_s[CHUNK-1] ^ b_sl_s[CHUNK-1];
    full_s = part_q;
    full_s[int'(idx_q) * CHUNK +: CHUNK] = sum_s;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    part_d  = part_q;
    radd_d  = radd_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Abort is ignored here; a Start is always honoured.
        if (Start) begin
          a_d     = DataA;
          b_d     = Sub ? ~DataB : DataB;
          carry_d = Sub ? ~CarryIn : CarryIn;
          idx_d   = {IDXW{1'b0}};
          part_d  = {WIDTH{1'b0}};
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort wins over completion; outputs keep their previous values.
        if (Abort) begin
          state_d = ST_IDLE;
          idx_d   = {IDXW{1'b0}};
        end else if (idx_q == LAST_IDX) begin
          part_d  = full_s;
          carry_d = chunk_cout_s;
          idx_d   = {IDXW{1'b0}};
          radd_d  = full_s;
          cout_d  = chunk_cout_s;
          ovf_d   = msb_cin_s ^ chunk_cout_s;
          zero_d  = (full_s == {WIDTH{1'b0}});
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          part_d  = full_s;
          carry_d = chunk_cout_s;
          idx_d   = idx_q + IDXW'(1'b1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDXW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      idx_q   <= {IDXW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      part_q  <= {WIDTH{1'b0}};
      radd_q  <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      radd_q  <= radd_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RAdd     = radd_q;
  assign CarryOut = cout_q;
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule
